// File: rtl/sb_tx_serializer_if.sv
// rtl/sb_tx_serializer_if.sv - message stream handshake between LTSM sub-state blocks and the SB TX serializer
interface sb_tx_serializer_if #(
  parameter int PKT_BITS = 64
);
  logic [PKT_BITS-1:0] msg_header_i;
  logic [PKT_BITS-1:0] msg_data_i;
  logic                msg_has_data_i;
  logic                msg_valid_i;
  logic                send_next_o;

  // Message source (sub-state block side)
  modport master (
    output msg_header_i,
    output msg_data_i,
    output msg_has_data_i,
    output msg_valid_i,
    input  send_next_o
  );

  // Serializer side
  modport slave (
    input  msg_header_i,
    input  msg_data_i,
    input  msg_has_data_i,
    input  msg_valid_i,
    output send_next_o
  );
endinterface

// File: rtl/sb_tx_serializer.sv
// rtl/sb_tx_serializer.sv - sideband TX serializer: header/data packets LSB first with forwarded clock and idle gap
module sb_tx_serializer #(
  parameter int PKT_BITS  = 64,
  parameter int GAP_UI    = 32,
  parameter int UI_CYCLES = 2
) (
  input  logic                  clk_800MHz,
  input  logic                  reset,
  input  logic                  enable_i,
  sb_tx_serializer_if.slave     msg_if,
  output logic                  busy_o,
  output logic                  SB_clkPin_TX_o,
  output logic                  SB_dataPin_TX_o
);

  localparam int GAP_CYC = GAP_UI * UI_CYCLES;
  localparam int BIT_W   = $clog2(PKT_BITS);
  localparam int GAP_W   = $clog2(GAP_CYC) + 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PKT_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_GAP
  } state_t;

  state_t              state_q,    state_d;
  logic [PKT_BITS-1:0] shift_q,    shift_d;
  logic [PKT_BITS-1:0] data_q,     data_d;
  logic                has_data_q, has_data_d;
  logic                in_data_q,  in_data_d;   // packet on the wire / just finished is the data packet
  logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic                phase_q,    phase_d;     // 0: clock low half of UI, 1: clock high half
  logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;

  logic send_next;
  logic busy;
  logic clk_pin;
  logic data_pin;

  // State, shift register and counters
  always_ff @(posedge clk_800MHz or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      data_q     <= '0;
      has_data_q <= 1'b0;
      in_data_q  <= 1'b0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      has_data_q <= has_data_d;
      in_data_q  <= in_data_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Next-state logic and pin/handshake outputs
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    data_d     = data_q;
    has_data_d = has_data_q;
    in_data_d  = in_data_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    gap_cnt_d  = gap_cnt_q;
    send_next  = 1'b0;
    busy       = 1'b0;
    clk_pin    = 1'b0;
    data_pin   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        send_next = enable_i;
        if (enable_i && msg_if.msg_valid_i) begin
          shift_d    = msg_if.msg_header_i;
          data_d     = msg_if.msg_data_i;
          has_data_d = msg_if.msg_has_data_i;
          in_data_d  = 1'b0;
          bit_cnt_d  = '0;
          phase_d    = 1'b0;
          gap_cnt_d  = '0;
          state_d    = ST_HDR;
        end
      end

      ST_HDR, ST_DATA: begin
        busy     = 1'b1;
        clk_pin  = phase_q;
        data_pin = shift_q[0];
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        busy = 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (!in_data_q && has_data_q) begin
            shift_d   = data_q;
            in_data_d = 1'b1;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            state_d   = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Dropping enable aborts the message outright; the partial packet is never resumed
    if (state_q != ST_IDLE && !enable_i) begin
      state_d    = ST_IDLE;
      shift_d    = '0;
      data_d     = '0;
      has_data_d = 1'b0;
      in_data_d  = 1'b0;
      bit_cnt_d  = '0;
      phase_d    = 1'b0;
      gap_cnt_d  = '0;
    end
  end

  // Ready is forced low while reset is held so every output reads 0 in reset
  assign msg_if.send_next_o = send_next & reset;
  assign busy_o             = busy;
  assign SB_clkPin_TX_o     = clk_pin;
  assign SB_dataPin_TX_o    = data_pin;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// tb/tb_sb_tx_serializer.sv - directed self-checking bench for sb_tx_serializer
module tb_sb_tx_serializer;

  logic clk_800MHz = 1'b0;
  logic reset;
  logic enable_i;
  logic busy_o;
  logic SB_clkPin_TX_o;
  logic SB_dataPin_TX_o;

  sb_tx_serializer_if #(.PKT_BITS(64)) msg_if ();

  sb_tx_serializer #(
    .PKT_BITS (64),
    .GAP_UI   (32),
    .UI_CYCLES(2)
  ) dut (
    .clk_800MHz     (clk_800MHz),
    .reset          (reset),
    .enable_i       (enable_i),
    .msg_if         (msg_if.slave),
    .busy_o         (busy_o),
    .SB_clkPin_TX_o (SB_clkPin_TX_o),
    .SB_dataPin_TX_o(SB_dataPin_TX_o)
  );

  always #5 clk_800MHz = ~clk_800MHz;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pin monitor: counts forwarded-clock rising edges, captures data LSB first on each,
  // and flags any cycle where ready is high while busy
  int          edges   = 0;
  int          viol    = 0;
  logic        prev_clk = 1'b0;
  logic [63:0] cap     = '0;

  always @(negedge clk_800MHz) begin
    if (SB_clkPin_TX_o && !prev_clk) begin
      edges <= edges + 1;
      cap   <= {SB_dataPin_TX_o, cap[63:1]};
    end
    prev_clk <= SB_clkPin_TX_o;
    if (msg_if.send_next_o && busy_o) viol <= viol + 1;
  end

  task automatic tick();
    @(negedge clk_800MHz);
    #1;
  endtask

  task automatic run_idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (SB_clkPin_TX_o || SB_dataPin_TX_o) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic offer(input logic [63:0] h, input logic [63:0] d, input logic hd);
    msg_if.msg_header_i   = h;
    msg_if.msg_data_i     = d;
    msg_if.msg_has_data_i = hd;
    msg_if.msg_valid_i    = 1'b1;
  endtask

  int base;
  int n;
  int ones;

  initial begin
    reset    = 1'b0;
    enable_i = 1'b1;
    offer(64'h0000_0000_0000_0001, 64'h0, 1'b0);

    // 1. reset state, then single header-only message
    repeat (3) tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_clkpin", 64'(SB_clkPin_TX_o), 64'd0);
    check("rst_datapin", 64'(SB_dataPin_TX_o), 64'd0);
    check("rst_send_next", 64'(msg_if.send_next_o), 64'd0);
    reset = 1'b1;
    #1;
    check("t1_accept_T", 64'(msg_if.send_next_o), 64'd1);
    base = edges;
    tick();                                     // T+1
    msg_if.msg_valid_i = 1'b0;
    check("t1_data_T1", 64'(SB_dataPin_TX_o), 64'd1);
    check("t1_clk_T1", 64'(SB_clkPin_TX_o), 64'd0);
    check("t1_busy_T1", 64'(busy_o), 64'd1);
    check("t1_ready_T1", 64'(msg_if.send_next_o), 64'd0);
    tick();                                     // T+2
    check("t1_data_T2", 64'(SB_dataPin_TX_o), 64'd1);
    check("t1_clk_T2", 64'(SB_clkPin_TX_o), 64'd1);
    ones = 0;
    for (int i = 0; i < 126; i++) begin         // T+3 .. T+128
      tick();
      if (SB_dataPin_TX_o) ones++;
    end
    check("t1_data_zero_after", 64'(ones), 64'd0);
    check("t1_edges", 64'(edges - base), 64'd64);
    check("t1_capture", cap, 64'h0000_0000_0000_0001);
    run_idle(64, "t1_gap_idle");                // T+192
    check("t1_ready_T192", 64'(msg_if.send_next_o), 64'd0);
    tick();                                     // T+193
    check("t1_ready_T193", 64'(msg_if.send_next_o), 64'd1);
    check("t1_busy_T193", 64'(busy_o), 64'd0);

    // 2 + 6. header + data, inputs scrambled right after accept
    offer(64'hA5A5_0000_FFFF_1234, 64'hDEAD_BEEF_0123_4567, 1'b1);
    #1;
    check("t2_accept", 64'(msg_if.send_next_o), 64'd1);
    base = edges;
    tick();                                     // T+1
    offer(64'h5A5A_FFFF_0000_EDCB, 64'h2152_4110_FEDC_BA98, 1'b0);
    msg_if.msg_valid_i = 1'b0;
    repeat (127) tick();                        // T+128
    check("t2_hdr_capture", cap, 64'hA5A5_0000_FFFF_1234);
    check("t2_hdr_edges", 64'(edges - base), 64'd64);
    run_idle(64, "t2_gap1_idle");               // T+192
    tick();                                     // T+193
    check("t2_data_busy", 64'(busy_o), 64'd1);
    check("t2_data_bit0", 64'(SB_dataPin_TX_o), 64'd1);
    check("t2_data_clk0", 64'(SB_clkPin_TX_o), 64'd0);
    repeat (127) tick();                        // T+320
    check("t2_data_capture", cap, 64'hDEAD_BEEF_0123_4567);
    check("t2_total_edges", 64'(edges - base), 64'd128);
    run_idle(64, "t2_gap2_idle");               // T+384
    check("t2_busy_T384", 64'(busy_o), 64'd1);
    tick();                                     // T+385
    check("t2_busy_T385", 64'(busy_o), 64'd0);
    check("t2_ready_T385", 64'(msg_if.send_next_o), 64'd1);

    // 3. valid held high: second accept exactly 193 cycles later
    offer(64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
    #1;
    check("t3_accept1", 64'(msg_if.send_next_o), 64'd1);
    tick();
    msg_if.msg_header_i = 64'hFEDC_BA98_7654_3210;
    n = 1;
    while (!msg_if.send_next_o && n < 400) begin
      tick();
      n++;
    end
    check("t3_accept_spacing", 64'(n), 64'd193);
    base = edges;
    tick();
    msg_if.msg_valid_i = 1'b0;
    repeat (127) tick();
    check("t3_second_capture", cap, 64'hFEDC_BA98_7654_3210);
    check("t3_second_edges", 64'(edges - base), 64'd64);
    run_idle(64, "t3_gap_idle");
    tick();
    check("t3_idle", 64'(busy_o), 64'd0);

    // 4. enable dropped at header bit 20, then a fresh message from bit0
    offer(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
    tick();                                     // T+1
    msg_if.msg_valid_i = 1'b0;
    repeat (40) tick();                         // T+41: bit 20 phase 0
    check("t4_mid_busy", 64'(busy_o), 64'd1);
    enable_i = 1'b0;
    tick();                                     // T+42
    check("t4_abort_clk", 64'(SB_clkPin_TX_o), 64'd0);
    check("t4_abort_data", 64'(SB_dataPin_TX_o), 64'd0);
    check("t4_abort_busy", 64'(busy_o), 64'd0);
    check("t4_abort_ready", 64'(msg_if.send_next_o), 64'd0);
    offer(64'h8000_0000_0000_0003, 64'h0, 1'b0);
    base = edges;
    repeat (3) tick();
    check("t4_disabled_ready", 64'(msg_if.send_next_o), 64'd0);
    check("t4_disabled_busy", 64'(busy_o), 64'd0);
    check("t4_disabled_edges", 64'(edges - base), 64'd0);
    enable_i = 1'b1;
    #1;
    check("t4_reenable_ready", 64'(msg_if.send_next_o), 64'd1);
    base = edges;
    tick();
    msg_if.msg_valid_i = 1'b0;
    repeat (127) tick();
    check("t4_capture", cap, 64'h8000_0000_0000_0003);
    check("t4_edges", 64'(edges - base), 64'd64);
    run_idle(64, "t4_gap_idle");
    tick();
    check("t4_idle", 64'(busy_o), 64'd0);

    // 5. asynchronous reset in the middle of the data packet
    offer(64'h1111_1111_1111_1111, 64'hFFFF_0000_FFFF_FFFF, 1'b1);
    tick();                                     // T+1
    msg_if.msg_valid_i = 1'b0;
    repeat (233) tick();                        // T+234: data bit 20 phase 1
    check("t5_pre_clk", 64'(SB_clkPin_TX_o), 64'd1);
    check("t5_pre_data", 64'(SB_dataPin_TX_o), 64'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_clk", 64'(SB_clkPin_TX_o), 64'd0);
    check("t5_rst_data", 64'(SB_dataPin_TX_o), 64'd0);
    check("t5_rst_busy", 64'(busy_o), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("t5_release_ready", 64'(msg_if.send_next_o), 64'd1);
    base = edges;
    repeat (10) tick();
    check("t5_no_spurious_edges", 64'(edges - base), 64'd0);
    check("t5_release_busy", 64'(busy_o), 64'd0);

    check("ready_while_busy", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
